// File: rtl/spram_ctl.sv
// Single-port synchronous RAM with byte-lane writes, selectable read-during-write
// policy, optional output register, valid strobe and a hardware clear sequencer.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | normal read/write access from the user port
// CLEAR | one word per cycle written with CLEAR_VALUE at the counter address
module spram_ctl #(
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 8,
  parameter int BYTE_WIDTH     = 8,
  parameter int RDW_MODE       = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0,
  localparam int LANES = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  busy,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  input  logic [LANES-1:0]      byteena,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   clr_cnt_q, clr_cnt_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [LANES-1:0]      mem_we;
  logic [DATA_WIDTH-1:0] rd_q;

  logic                  rd_fire;
  logic                  rd_v;
  logic                  q_zero;
  logic [LANES-1:0]      be_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [DATA_WIDTH-1:0] q_raw;

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Counter carries one spare MSB: it sets exactly when the last address is written.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_addr  = address;
    mem_wdata = data;
    mem_we    = '0;
    rd_fire   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wren) mem_we = byteena;
        rd_fire = rden && (!wren || (RDW_MODE != 2));
        if (clear) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        mem_addr  = clr_cnt_q[ADDR_WIDTH-1:0];
        mem_wdata = CLEAR_VALUE;
        mem_we    = '1;
        clr_cnt_d = clr_cnt_q + CNT_ONE;
        if (clr_cnt_d[ADDR_WIDTH]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == CLEAR);

  // Array: no reset, per-lane write enables, registered read of pre-write contents.
  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (mem_we[i]) mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    if (rd_fire) rd_q <= mem[mem_addr];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_v   <= 1'b0;
      q_zero <= 1'b1;
      be_r   <= '0;
      data_r <= '0;
    end else begin
      rd_v <= rd_fire;
      if (rd_fire) begin
        q_zero <= 1'b0;
        be_r   <= ((RDW_MODE == 1) && wren) ? byteena : '0;
        data_r <= data;
      end
    end
  end

  // Write-through merge happens after the RAM so the array stays a plain block RAM.
  always_comb begin
    q_raw = rd_q;
    for (int i = 0; i < LANES; i++) begin
      if (be_r[i]) q_raw[i*BYTE_WIDTH +: BYTE_WIDTH] = data_r[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    if (q_zero) q_raw = '0;
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [DATA_WIDTH-1:0] q_p;
      logic                  v_p;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          q_p <= '0;
          v_p <= 1'b0;
        end else begin
          v_p <= rd_v;
          if (rd_v) q_p <= q_raw;
        end
      end
      assign q       = q_p;
      assign q_valid = v_p;
    end else begin : g_noreg
      assign q       = q_raw;
      assign q_valid = rd_v;
    end
  endgenerate

endmodule

// File: tb/tb_spram_ctl.sv
// Directed bench for spram_ctl: four instances (RDW 0/1/2 unregistered, RDW 0
// registered) share one stimulus stream and are checked against hand values.
module tb_spram_ctl;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic [3:0]  address;
  logic [15:0] data;
  logic        wren;
  logic [1:0]  byteena;
  logic        rden;

  logic        b0, b1, b2, b3;
  logic        v0, v1, v2, v3;
  logic [15:0] q0, q1, q2, q3;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  spram_ctl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .RDW_MODE(0), .OUT_REG(0),
              .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h00A5)) u0 (
    .clock(clock), .reset(reset), .clear(clear), .busy(b0), .address(address), .data(data),
    .wren(wren), .byteena(byteena), .rden(rden), .q(q0), .q_valid(v0));

  spram_ctl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .RDW_MODE(1), .OUT_REG(0),
              .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h00A5)) u1 (
    .clock(clock), .reset(reset), .clear(clear), .busy(b1), .address(address), .data(data),
    .wren(wren), .byteena(byteena), .rden(rden), .q(q1), .q_valid(v1));

  spram_ctl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .RDW_MODE(2), .OUT_REG(0),
              .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h00A5)) u2 (
    .clock(clock), .reset(reset), .clear(clear), .busy(b2), .address(address), .data(data),
    .wren(wren), .byteena(byteena), .rden(rden), .q(q2), .q_valid(v2));

  spram_ctl #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .RDW_MODE(0), .OUT_REG(1),
              .CLEAR_ON_RESET(1), .CLEAR_VALUE(16'h00A5)) u3 (
    .clock(clock), .reset(reset), .clear(clear), .busy(b3), .address(address), .data(data),
    .wren(wren), .byteena(byteena), .rden(rden), .q(q3), .q_valid(v3));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    address = a;
    data    = d;
    byteena = be;
    wren    = 1'b1;
    step();
    wren    = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1; clear = 1'b0; wren = 1'b0; rden = 1'b0;
    address = '0; data = '0; byteena = '0;
    #2;
    checks++;
    if ({b3, b2, b1, b0} !== 4'hF) begin
      errors++; $display("FAIL reset_busy: got %b expected 1111", {b3, b2, b1, b0});
    end
    checks++;
    if ({q0, q1, q2, q3} !== 64'h0) begin
      errors++; $display("FAIL reset_q: got %h %h %h %h expected all 0", q0, q1, q2, q3);
    end
    checks++;
    if ({v3, v2, v1, v0} !== 4'h0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0000", {v3, v2, v1, v0});
    end
    step(); step();
    reset = 1'b0;
    cnt = 0;
    while (b0 && cnt < 40) begin
      step();
      cnt++;
    end
    checks++;
    if (cnt !== 16) begin
      errors++; $display("FAIL reset_clear_len: got %0d cycles expected 16", cnt);
    end
    checks++;
    if ({b3, b2, b1} !== 3'b000) begin
      errors++; $display("FAIL reset_busy_end: got %b expected 000", {b3, b2, b1});
    end
  endtask

  task automatic test_clear_fill();
    for (int i = 0; i < 16; i++) begin
      address = 4'(i);
      rden    = 1'b1;
      step();
      checks++;
      if (q0 !== 16'h00A5 || v0 !== 1'b1) begin
        errors++; $display("FAIL fill_read[%0d]: got %h/%b expected 00a5/1", i, q0, v0);
      end
      if (i > 0) begin
        checks++;
        if (q3 !== 16'h00A5 || v3 !== 1'b1) begin
          errors++; $display("FAIL fill_read_oreg[%0d]: got %h/%b expected 00a5/1", i, q3, v3);
        end
      end
    end
    rden = 1'b0;
    step();
    checks++;
    if (q3 !== 16'h00A5 || v3 !== 1'b1 || v0 !== 1'b0) begin
      errors++; $display("FAIL fill_tail: got q3=%h v3=%b v0=%b expected 00a5/1/0", q3, v3, v0);
    end
  endtask

  task automatic test_byte_enable();
    do_write(4'd3, 16'h1234, 2'b11);
    do_write(4'd3, 16'hFF00, 2'b10);
    address = 4'd3;
    rden = 1'b1;
    step();
    rden = 1'b0;
    checks++;
    if (q0 !== 16'hFF34 || q1 !== 16'hFF34 || q2 !== 16'hFF34 || v0 !== 1'b1) begin
      errors++; $display("FAIL be_read: got %h %h %h v=%b expected ff34 x3 v=1", q0, q1, q2, v0);
    end
    step();
    checks++;
    if (q3 !== 16'hFF34 || v3 !== 1'b1) begin
      errors++; $display("FAIL be_read_oreg: got %h/%b expected ff34/1", q3, v3);
    end
    checks++;
    if (q0 !== 16'hFF34 || v0 !== 1'b0) begin
      errors++; $display("FAIL idle_hold: got %h/%b expected ff34/0", q0, v0);
    end
  endtask

  task automatic test_rdw();
    do_write(4'd5, 16'h0001, 2'b11);
    address = 4'd5;
    rden = 1'b1;
    step();
    wren = 1'b1; data = 16'hBEEF; byteena = 2'b11;
    step();
    wren = 1'b0; rden = 1'b0;
    checks++;
    if (q0 !== 16'h0001 || v0 !== 1'b1) begin
      errors++; $display("FAIL rdw_old: got %h/%b expected 0001/1", q0, v0);
    end
    checks++;
    if (q1 !== 16'hBEEF || v1 !== 1'b1) begin
      errors++; $display("FAIL rdw_new: got %h/%b expected beef/1", q1, v1);
    end
    checks++;
    if (q2 !== 16'h0001 || v2 !== 1'b0) begin
      errors++; $display("FAIL rdw_hold: got %h/%b expected 0001/0", q2, v2);
    end
    wren = 1'b1; data = 16'h1200; byteena = 2'b10;
    step();
    wren = 1'b0;
    checks++;
    if (q1 !== 16'hBEEF || v1 !== 1'b0 || q0 !== 16'h0001 || v0 !== 1'b0) begin
      errors++; $display("FAIL write_only_hold: got %h/%b %h/%b expected beef/0 0001/0", q1, v1, q0, v0);
    end
    wren = 1'b1; rden = 1'b1; data = 16'h00CD; byteena = 2'b01;
    step();
    wren = 1'b0; rden = 1'b0;
    checks++;
    if (q0 !== 16'h12EF || q1 !== 16'h12CD || q2 !== 16'h0001 || v2 !== 1'b0) begin
      errors++; $display("FAIL rdw_partial: got %h %h %h/%b expected 12ef 12cd 0001/0", q0, q1, q2, v2);
    end
    rden = 1'b1;
    step();
    rden = 1'b0;
    checks++;
    if (q0 !== 16'h12CD || q1 !== 16'h12CD || q2 !== 16'h12CD || v2 !== 1'b1) begin
      errors++; $display("FAIL rdw_after: got %h %h %h/%b expected 12cd x3 /1", q0, q1, q2, v2);
    end
    step();
  endtask

  task automatic test_out_reg();
    do_write(4'd0, 16'd10, 2'b11);
    do_write(4'd1, 16'd11, 2'b11);
    do_write(4'd2, 16'd12, 2'b11);
    rden = 1'b1;
    address = 4'd0;
    step();
    checks++;
    if (v3 !== 1'b0 || q0 !== 16'd10 || v0 !== 1'b1) begin
      errors++; $display("FAIL oreg_c1: got v3=%b q0=%h v0=%b expected 0/000a/1", v3, q0, v0);
    end
    address = 4'd1;
    step();
    checks++;
    if (q3 !== 16'd10 || v3 !== 1'b1 || q0 !== 16'd11) begin
      errors++; $display("FAIL oreg_c2: got q3=%h/%b q0=%h expected 000a/1 000b", q3, v3, q0);
    end
    address = 4'd2;
    step();
    rden = 1'b0;
    checks++;
    if (q3 !== 16'd11 || v3 !== 1'b1 || q0 !== 16'd12) begin
      errors++; $display("FAIL oreg_c3: got q3=%h/%b q0=%h expected 000b/1 000c", q3, v3, q0);
    end
    step();
    checks++;
    if (q3 !== 16'd12 || v3 !== 1'b1) begin
      errors++; $display("FAIL oreg_c4: got %h/%b expected 000c/1", q3, v3);
    end
    step();
    checks++;
    if (q3 !== 16'd12 || v3 !== 1'b0) begin
      errors++; $display("FAIL oreg_c5: got %h/%b expected 000c/0", q3, v3);
    end
  endtask

  task automatic test_clear_mid_use();
    int cnt;
    do_write(4'd7, 16'h1357, 2'b11);
    clear = 1'b1;
    step();
    clear = 1'b0;
    wren = 1'b1; rden = 1'b1; address = 4'd7; data = 16'hDEAD; byteena = 2'b11;
    cnt = 0;
    while (b0 && cnt < 40) begin
      step();
      cnt++;
      checks++;
      if ({v3, v2, v1, v0} !== 4'h0) begin
        errors++; $display("FAIL clear_valid[%0d]: got %b expected 0000", cnt, {v3, v2, v1, v0});
      end
    end
    wren = 1'b0; rden = 1'b0;
    checks++;
    if (cnt !== 16) begin
      errors++; $display("FAIL clear_len: got %0d cycles expected 16", cnt);
    end
    checks++;
    if (q0 !== 16'd12 || q1 !== 16'd12 || q2 !== 16'd12 || q3 !== 16'd12) begin
      errors++; $display("FAIL clear_q_hold: got %h %h %h %h expected 000c x4", q0, q1, q2, q3);
    end
    address = 4'd7; rden = 1'b1;
    step();
    address = 4'd0;
    step();
    rden = 1'b0;
    checks++;
    if (q3 !== 16'h00A5 || q0 !== 16'h00A5) begin
      errors++; $display("FAIL clear_addr7_0: got q3=%h q0=%h expected 00a5 00a5", q3, q0);
    end
    step();
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    do_write(4'd12, 16'h4242, 2'b11);
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (9) step();
    reset = 1'b1;
    #1;
    checks++;
    if ({b3, b2, b1, b0} !== 4'hF) begin
      errors++; $display("FAIL rst_mid_busy: got %b expected 1111", {b3, b2, b1, b0});
    end
    checks++;
    if ({q0, q1, q2, q3} !== 64'h0 || {v3, v2, v1, v0} !== 4'h0) begin
      errors++; $display("FAIL rst_mid_q: got %h %h %h %h v=%b expected zeros", q0, q1, q2, q3, {v3, v2, v1, v0});
    end
    step(); step();
    reset = 1'b0;
    cnt = 0;
    while (b0 && cnt < 40) begin
      step();
      cnt++;
    end
    checks++;
    if (cnt !== 16) begin
      errors++; $display("FAIL rst_mid_len: got %0d cycles expected 16", cnt);
    end
    address = 4'd12; rden = 1'b1;
    step();
    rden = 1'b0;
    checks++;
    if (q0 !== 16'h00A5 || v0 !== 1'b1) begin
      errors++; $display("FAIL rst_mid_addr12: got %h/%b expected 00a5/1", q0, v0);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_clear_fill();
    test_byte_enable();
    test_rdw();
    test_out_reg();
    test_clear_mid_use();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spram_ctl.md
Name: spram_ctl

Overview:
- Parametrised single-port synchronous RAM with generalised width and depth.
- Adds per-lane byte-enable writes, a selectable read-during-write policy, an optional output register stage and a valid strobe.
- Includes a hardware clear sequencer that fills the whole array with a constant after reset or on request.
- Used by the arcade cores for CPU work RAM, palette RAM and sprite RAM that the game code expects to start zeroed.

Parameters:
- ADDR_WIDTH, 15, address bits; depth = 2^ADDR_WIDTH words.
- DATA_WIDTH, 8, word width; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, byte-lane width; LANES = DATA_WIDTH/BYTE_WIDTH (derived).
- RDW_MODE, 0, read-during-write policy: 0 = old data, 1 = new data (write-through), 2 = q held.
- OUT_REG, 0, 1 adds one pipeline register on q and q_valid.
- CLEAR_ON_RESET, 1, 1 starts a clear sequence when reset releases.
- CLEAR_VALUE, 0, DATA_WIDTH-wide fill value written by the clear sequencer.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- clear  in  1  one-cycle request to start a clear sequence; honoured only in IDLE.
- busy  out  1  high while a clear is in progress.
- address  in  ADDR_WIDTH  word address.
- data  in  DATA_WIDTH  write data.
- wren  in  1  write enable.
- byteena  in  LANES  per-lane write mask; lane i covers bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- rden  in  1  read enable.
- q  out  DATA_WIDTH  read data.
- q_valid  out  1  one-cycle strobe marking new read data on q.

Behaviour:
- Reset (asynchronous):
  - q = 0, q_valid = 0, pipeline registers = 0, clear counter = 0.
  - State = CLEAR if CLEAR_ON_RESET = 1, otherwise IDLE; busy follows the state immediately.
  - Memory contents are not reset.
- FSM states:
  - IDLE: normal access.
  - CLEAR: one word per cycle is written with CLEAR_VALUE at counter address; counter increments each cycle.
  - After the write to address 2^ADDR_WIDTH-1, the state returns to IDLE and busy falls on that same edge.
  - A full clear takes exactly 2^ADDR_WIDTH cycles.
- IDLE → CLEAR: clear high in IDLE; the first clear write happens on the next edge.
- During CLEAR:
  - wren, rden and clear are ignored.
  - q holds its value; q_valid = 0.
  - Reset asserted mid-clear restarts per the reset rule; a partial fill is acceptable.
- Write (IDLE, wren = 1): for each lane with byteena[i] = 1, mem[address] lane i ← data lane i. Masked lanes are unchanged. byteena all-zero performs no write.
- Read (IDLE, rden = 1, wren = 0):
  - OUT_REG = 0: q = mem[address] on the next edge, q_valid = 1 for that one cycle.
  - OUT_REG = 1: both q and q_valid arrive one cycle later (latency 2).
  - Back-to-back reads are allowed every cycle, giving one result per cycle.
- Read and write together (rden = 1, wren = 1):
  - RDW_MODE 0: q = contents before the write, q_valid = 1.
  - RDW_MODE 1: q = merged word, i.e. enabled lanes from data and the other lanes from the old contents; q_valid = 1.
  - RDW_MODE 2: q holds, q_valid = 0.
- wren = 1 with rden = 0: q holds, q_valid = 0. This matches the legacy behaviour of q updating only on reads.
- Idle cycles: q holds its value and q_valid = 0.
- Address wrap: the clear counter is ADDR_WIDTH+1 bits wide and the terminal test uses the MSB, so no address is skipped or written twice.
- Synthesis: the array must infer block RAM. Lane writes use a per-lane write-enable loop; there is no reset on the array.

Test Plan:
- ADDR_WIDTH=4, CLEAR_VALUE=8'hA5, CLEAR_ON_RESET=1: release reset → busy high for exactly 16 cycles, then reading every address returns 8'hA5 with q_valid one cycle after rden.
- DATA_WIDTH=16: write 16'h1234 with byteena=2'b11 to addr 3, then 16'hFF00 with byteena=2'b10 → reading addr 3 returns 16'hFF34.
- RDW sweep on addr 5 holding 16'h0001, write 16'hBEEF with byteena=11 and rden=1:
  - RDW_MODE 0 → q=16'h0001.
  - RDW_MODE 1 → q=16'hBEEF.
  - RDW_MODE 2 → q unchanged and q_valid=0.
- OUT_REG=1: reads on consecutive cycles to addrs 0,1,2 (holding 10,11,12) → q=10,11,12 on cycles 2,3,4 with q_valid high on each.
- Clear mid-use: pulse clear after writing addr 7, then issue wren and rden during busy → both ignored, q_valid stays 0, addr 7 reads CLEAR_VALUE afterwards.
- Reset asserted at clear counter = 9 → busy remains high, q=0 immediately, and a full 16-cycle clear reruns after release.
